// File: rtl/filtro_pb_pkg.sv
// Shared types and width helpers for the FiltroPB controller.
package filtro_pb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_STROBE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DECIDE = 3'd4
  } state_t;

  function automatic int win_width(input int samples, input int osf);
    return samples * osf;
  endfunction

  function automatic int sum_width(input int samples, input int osf);
    return $clog2(samples * osf) + 1;
  endfunction

endpackage

// File: rtl/filtro_pb_win.sv
// Oversampled bit window: shift register plus saturating fill and modulo-OSF phase counters.
module filtro_pb_win
  import filtro_pb_pkg::*;
#(
  parameter int SAMPLES = 2,
  parameter int OSF     = 8,
  localparam int W      = win_width(SAMPLES, OSF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         bit_i,
  input  logic         bit_valid_i,
  output logic [W-1:0] win_o,
  output logic [W-1:0] win_next_o,
  output logic         wrap_o,
  output logic         trig_o
);

  localparam int FW = $clog2(W + 1);
  localparam int PW = $clog2(OSF);

  logic [W-1:0]  win_q, win_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          accept;
  logic          full;

  assign accept     = en_i & bit_valid_i;
  assign full       = (fill_q == FW'(W));
  assign win_next_o = {win_q[W-2:0], bit_i};
  assign win_o      = win_q;
  assign wrap_o     = accept & (phase_q == PW'(OSF - 1));
  // First window completes when fill hits W; afterwards every phase wrap is a new window.
  assign trig_o     = accept & ((fill_q == FW'(W - 1)) | (full & (phase_q == PW'(OSF - 1))));

  always_comb begin
    win_d   = win_q;
    fill_d  = fill_q;
    phase_d = phase_q;
    if (!en_i) begin
      fill_d  = '0;
      phase_d = '0;
    end else if (bit_valid_i) begin
      win_d   = win_next_o;
      fill_d  = full ? fill_q : fill_q + 1'b1;
      phase_d = (phase_q == PW'(OSF - 1)) ? '0 : phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q   <= '0;
      fill_q  <= '0;
      phase_q <= '0;
    end else begin
      win_q   <= win_d;
      fill_q  <= fill_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/filtro_pb_ctrl.sv
// Sequences window snapshots into an external FiltroPB and thresholds its sum into symbols.
module filtro_pb_ctrl
  import filtro_pb_pkg::*;
#(
  parameter int SAMPLES = 2,
  parameter int OSF     = 8,
  localparam int W      = win_width(SAMPLES, OSF),
  localparam int SW     = sum_width(SAMPLES, OSF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          bit_in,
  input  logic          bit_valid,
  input  logic [SW-1:0] thresh,
  output logic          filt_p,
  output logic [W-1:0]  filt_data,
  input  logic [SW-1:0] filt_sum,
  output logic          bit_out,
  output logic          bit_out_valid,
  output logic          overrun,
  output state_t        state_dbg
);

  // Qualifiers, no backpressure: bit_valid marks one input bit per high cycle,
  // bit_out_valid marks one decided symbol per high cycle; neither side can stall.

  state_t        state_q, state_d;
  logic [W-1:0]  filt_data_q;
  logic [W-1:0]  win;
  logic [W-1:0]  win_next;
  logic          bit_out_q;
  logic          overrun_q;
  logic          wrap;
  logic          trig;
  logic          decision;
  logic          busy;

  filtro_pb_win #(
    .SAMPLES(SAMPLES),
    .OSF    (OSF)
  ) u_win (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en),
    .bit_i      (bit_in),
    .bit_valid_i(bit_valid),
    .win_o      (win),
    .win_next_o (win_next),
    .wrap_o     (wrap),
    .trig_o     (trig)
  );

  assign decision = (filt_sum >= thresh);
  assign busy     = (state_q == ST_STROBE) || (state_q == ST_WAIT) || (state_q == ST_DECIDE);

  always_comb begin
    state_d       = state_q;
    filt_p        = 1'b0;
    bit_out_valid = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_FILL;
        ST_FILL:   if (trig) state_d = ST_STROBE;
        ST_STROBE: begin
          filt_p  = 1'b1;
          state_d = ST_WAIT;
        end
        ST_WAIT:   state_d = ST_DECIDE;
        ST_DECIDE: begin
          bit_out_valid = 1'b1;
          state_d       = ST_FILL;
        end
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      filt_data_q <= '0;
      bit_out_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_FILL) && (state_d == ST_STROBE)) filt_data_q <= win_next;
      if (bit_out_valid) bit_out_q <= decision;
      // A window completing while the previous one is still in flight is dropped.
      if (wrap && busy) overrun_q <= 1'b1;
    end
  end

  // The decided value is visible in the DECIDE cycle itself, then held.
  assign bit_out   = bit_out_valid ? decision : bit_out_q;
  assign filt_data = filt_data_q;
  assign overrun   = overrun_q;
  assign state_dbg = state_q;

endmodule

// File: doc/filtro_pb_ctrl.md
FILTRO_PB_CTRL -- requirements
Module: filtro_pb_ctrl

Interface
REQ-001 Parameter SAMPLES, default 2, symbols per filter window.
REQ-002 Parameter OSF, default 8, oversampling factor (bits per symbol); SHALL be >= 4.
REQ-003 Localparam W = SAMPLES*OSF (window width); SW = $clog2(W)+1 (sum width).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 en  input  1  enable; low forces IDLE.
REQ-007 bit_in  input  1  oversampled serial data bit.
REQ-008 bit_valid  input  1  bit_in qualifier, one bit per asserted cycle.
REQ-009 thresh  input  SW  decision threshold.
REQ-010 filt_p  output  1  strobe to FiltroPB P.
REQ-011 filt_data  output  W  window snapshot to FiltroPB DataIn.
REQ-012 filt_sum  input  SW  FiltroPB DataOut.
REQ-013 bit_out  output  1  decided symbol.
REQ-014 bit_out_valid  output  1  one-cycle qualifier for bit_out.
REQ-015 overrun  output  1  sticky: OSF bits arrived before previous decision completed.

Function
REQ-016 Shift register win[W-1:0] SHALL shift in bit_in at LSB on every cycle with bit_valid=1 and en=1, independent of FSM state.
REQ-017 fill counter SHALL count accepted bits up to W and saturate; phase counter SHALL count accepted bits modulo OSF.
REQ-018 FSM states: IDLE, FILL, STROBE, WAIT, DECIDE.
REQ-019 IDLE -> FILL when en=1.
REQ-020 FILL -> STROBE on the cycle fill reaches W (first window) or, once full, on every phase wrap OSF-1 -> 0.
REQ-021 Entering STROBE SHALL latch filt_data <= win (including the bit accepted that cycle); filt_data SHALL hold until the next STROBE.
REQ-022 STROBE: filt_p=1 for exactly one cycle; -> WAIT.
REQ-023 WAIT: filt_p=0; one cycle for filter settling; -> DECIDE.
REQ-024 DECIDE: bit_out <= (filt_sum >= thresh), unsigned compare; bit_out_valid=1 for one cycle; -> FILL.
REQ-025 Latency: bit_out_valid asserts 3 cycles after the cycle that accepted the triggering bit.
REQ-026 thresh=0 SHALL yield bit_out=1; thresh>W SHALL yield bit_out=0.
REQ-027 A phase wrap while in STROBE, WAIT or DECIDE SHALL set overrun and SHALL NOT start a second decision; the window is then skipped.
REQ-028 en deasserted in any state: next state IDLE, fill and phase counters cleared, filt_p=0, no bit_out_valid, win and filt_data retained.
REQ-029 bit_out SHALL hold its last value between valids.

Reset
REQ-030 rst=1 SHALL on the next edge set state=IDLE, win=0, filt_data=0, fill=0, phase=0, filt_p=0, bit_out=0, bit_out_valid=0, overrun=0.
REQ-031 rst asserted mid-decision SHALL abort it; no bit_out_valid is emitted for that window.
REQ-032 overrun SHALL clear only on rst.

Structure
REQ-033 Package filtro_pb_pkg SHALL hold the FSM state enum and the W/SW width helper functions.
REQ-034 One sub-module is natural: filtro_pb_win (shift register plus fill/phase counters); FiltroPB is instantiated outside this block.

Verification (SAMPLES=2, OSF=8, W=16, SW=5, FiltroPB connected)
REQ-035 16 consecutive valid 1-bits, thresh=9 -> single filt_p pulse, filt_data=16'hFFFF, bit_out=1 with bit_out_valid 3 cycles after 16th bit.
REQ-036 Continuous 8'hFF followed by 8'h00 pattern, thresh=9 -> after initial fill, one decision per 8 bits, filt_sum=8 each, bit_out=0 each.
REQ-037 thresh=0 with all-zero input -> bit_out=1; thresh=17 with all-one input -> bit_out=0.
REQ-038 bit_valid toggling every other cycle -> decisions every 16 cycles, no overrun.
REQ-039 en dropped 2 bits after a phase wrap, re-raised -> no valid during low, full 16-bit refill before next decision.
REQ-040 rst asserted in WAIT -> no bit_out_valid, all outputs 0 next cycle, overrun=0.
